mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter WAIT_CYC, default 2: number of ACCESS cycles per transfer; legal range 1..15; 0 SHALL behave as 1.
REQ-002 clk  in  1  single system clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 addr  in  16  CPU byte address, driven by the CPU AR output.
REQ-005 din  in  8  CPU write data, driven by the CPU data_out bus.
REQ-006 read  in  1  CPU read request, level-held until ready is seen.
REQ-007 write  in  1  CPU write request, level-held until ready is seen.
REQ-008 dout  out  8  read data registered to the CPU data_in bus.
REQ-009 ready  out  1  transfer complete; dout is valid for reads while ready=1.
REQ-010 err  out  1  sticky protocol-error flag.
REQ-011 ext_addr  out  16  external SRAM address, registered.
REQ-012 ext_wdata  out  8  external SRAM write data, registered.
REQ-013 ext_rdata  in  8  external SRAM read data.
REQ-014 ext_ce_n, ext_oe_n, ext_we_n  out  1 each  active-low SRAM strobes.

Function
REQ-015 FSM states: IDLE, SETUP, ACCESS, HOLD.
REQ-016 IDLE: with exactly one of read/write high, latch addr into ext_addr, latch din into ext_wdata (write only), record direction, and go to SETUP.
REQ-017 IDLE: with read=1 and write=1, set err=1, start no access, and stay in IDLE.
REQ-018 SETUP, one cycle: ext_ce_n=0; ext_oe_n=1 and ext_we_n=1; next state ACCESS; wait counter loaded with WAIT_CYC-1.
REQ-019 ACCESS, WAIT_CYC cycles: ext_ce_n=0 throughout.
REQ-020 ACCESS, read: ext_oe_n=0; on the final ACCESS edge, capture ext_rdata into dout.
REQ-021 ACCESS, write: ext_we_n=0.
REQ-022 ACCESS: the counter decrements each cycle; at 0, go to HOLD.
REQ-023 HOLD: ext_ce_n, ext_oe_n and ext_we_n all 1; ext_addr and ext_wdata unchanged; ready=1.
REQ-024 HOLD: stay in HOLD while read or write is high; return to IDLE on the first cycle both are low, with ready=0 from that edge. This guarantees one access per request.
REQ-025 Latency: with the request sampled in IDLE at edge N, ready rises after edge N+1+WAIT_CYC (default: 3 cycles).
REQ-026 Request changes during SETUP and ACCESS SHALL be ignored; the latched addr, din and direction are used.
REQ-027 dout SHALL hold the last read value until the next read capture; writes do not alter it.
REQ-028 err is set only per REQ-017 and SHALL clear only on reset.
REQ-029 ext_we_n and ext_oe_n SHALL never be 0 in the same cycle.
REQ-030 Both SHALL be 1 in every state except ACCESS.

Reset
REQ-031 rst=0 SHALL immediately force, without waiting for a clock edge: state IDLE, ext_ce_n/ext_oe_n/ext_we_n=1, ready=0, err=0, dout=8'h00, ext_addr=16'h0000, ext_wdata=8'h00.
REQ-032 Reset asserted mid-ACCESS SHALL abort the transfer: strobes rise asynchronously, and no data is captured.
REQ-033 After reset release, the first access starts from IDLE on the next valid request.

Structure
REQ-034 A shared package mem_pkg SHALL hold the state encoding (2-bit, IDLE=0, SETUP=1, ACCESS=2, HOLD=3) and the WAIT_CYC default constant.
REQ-035 A single sub-module ws_counter SHALL implement the 4-bit loadable down-counter with a zero flag, with the same clk and rst.
REQ-036 All outputs SHALL be registered; no combinational path from the CPU inputs to the ext_* outputs.

Verification
REQ-037 Read, WAIT_CYC=2, SRAM[0x1234]=0xA5: read=1 with addr=0x1234 -> ext_oe_n low for 2 cycles, ready=1 at cycle 3, dout=0xA5, ext_we_n constant 1.
REQ-038 Write, addr=0x00FF, din=0x3C -> ext_we_n low exactly WAIT_CYC cycles, ext_wdata=0x3C stable from SETUP through HOLD, a subsequent read returns 0x3C.
REQ-039 Read held 5 extra cycles after ready -> state stays HOLD and exactly one SETUP/ACCESS sequence occurs; dropping read -> IDLE next edge.
REQ-040 read=1 and write=1 together in IDLE -> err=1, all strobes stay 1; err persists through later good transfers until rst=0.
REQ-041 rst=0 asserted in the 2nd ACCESS cycle of a read with dout=0x11 -> strobes 1 and dout=0x00 without waiting for a clock edge; after release, a new read of 0x5A completes normally.
REQ-042 WAIT_CYC=0 and WAIT_CYC=15 -> ACCESS lasts 1 and 15 cycles respectively; addr changes during ACCESS do not reach ext_addr.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM controller: FSM encoding, default wait count
// and the wait-count load helper.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    localparam int WAIT_CYC_DEF = 2;

    // Counter preload for a given ACCESS length; 0 acts as 1, above 15 acts as 15.
    function automatic logic [3:0] wait_load(input int w);
        if (w <= 1)
            return 4'd0;
        else if (w >= 15)
            return 4'd14;
        else
            return 4'(w - 1);
    endfunction

endpackage

// File: rtl/ws_counter.sv
// 4-bit loadable down-counter with zero flag; paces the ACCESS phase.
module ws_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= 4'd0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mem_ctrl.sv
// CPU-to-async-SRAM controller: IDLE/SETUP/ACCESS/HOLD handshake with
// registered strobes, address and data.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int WAIT_CYC = WAIT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  din,
    input  logic        read,
    input  logic        write,
    output logic [7:0]  dout,
    output logic        ready,
    output logic        err,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    output logic        ext_ce_n,
    output logic        ext_oe_n,
    output logic        ext_we_n
);

    localparam logic [3:0] LOAD_VAL = wait_load(WAIT_CYC);

    state_e state, nxt;
    logic   rd_q;
    logic   cnt_zero;
    logic   req_one, req_both;
    logic   ce_d, oe_d, we_d, rdy_d;

    assign req_one  = read ^ write;
    assign req_both = read & write;

    ws_counter u_ws (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ST_SETUP),
        .load_val (LOAD_VAL),
        .dec      (state == ST_ACCESS),
        .zero     (cnt_zero)
    );

    always_comb begin
        nxt   = state;
        ce_d  = 1'b1;
        oe_d  = 1'b1;
        we_d  = 1'b1;
        rdy_d = 1'b0;
        case (state)
            ST_IDLE:   if (req_one) nxt = ST_SETUP;
            ST_SETUP:  nxt = ST_ACCESS;
            ST_ACCESS: if (cnt_zero) nxt = ST_HOLD;
            ST_HOLD:   if (!read && !write) nxt = ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
        // Strobes are registered from the next state, so they line up with it.
        ce_d  = !(nxt == ST_SETUP || nxt == ST_ACCESS);
        oe_d  = !(nxt == ST_ACCESS && rd_q);
        we_d  = !(nxt == ST_ACCESS && !rd_q);
        rdy_d = (nxt == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rd_q      <= 1'b0;
            dout      <= 8'h00;
            ready     <= 1'b0;
            err       <= 1'b0;
            ext_addr  <= 16'h0000;
            ext_wdata <= 8'h00;
            ext_ce_n  <= 1'b1;
            ext_oe_n  <= 1'b1;
            ext_we_n  <= 1'b1;
        end else begin
            state    <= nxt;
            ready    <= rdy_d;
            ext_ce_n <= ce_d;
            ext_oe_n <= oe_d;
            ext_we_n <= we_d;
            if (state == ST_IDLE && req_one) begin
                ext_addr <= addr;
                rd_q     <= read;
                if (write)
                    ext_wdata <= din;
            end
            if (state == ST_IDLE && req_both)
                err <= 1'b1;
            if (state == ST_ACCESS && cnt_zero && rd_q)
                dout <= ext_rdata;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench: three controllers (WAIT_CYC 2, 0, 15) share the CPU side
// and one SRAM model; instance 0 is the only one allowed to write the SRAM.
module tb_mem_ctrl;

    localparam int N = 3;

    logic              clk, rst, read, write;
    logic [15:0]       addr;
    logic [7:0]        din;
    logic [N-1:0]      ready, err, ce_n, oe_n, we_n;
    logic [7:0]        dout      [N];
    logic [15:0]       ext_addr  [N];
    logic [7:0]        ext_wdata [N];
    logic [7:0]        ext_rdata [N];
    logic [7:0]        mem [0:65535];

    int n_chk = 0, n_fail = 0;
    int oe_cnt[N], we_cnt[N], seq_cnt[N];
    int ovl_cnt = 0;
    bit [N-1:0] ce_prev = '1;

    function automatic int weff(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int WC = (g == 0) ? 2 : ((g == 1) ? 0 : 15);
        mem_ctrl #(.WAIT_CYC(WC)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .addr      (addr),
            .din       (din),
            .read      (read),
            .write     (write),
            .dout      (dout[g]),
            .ready     (ready[g]),
            .err       (err[g]),
            .ext_addr  (ext_addr[g]),
            .ext_wdata (ext_wdata[g]),
            .ext_rdata (ext_rdata[g]),
            .ext_ce_n  (ce_n[g]),
            .ext_oe_n  (oe_n[g]),
            .ext_we_n  (we_n[g])
        );
        assign ext_rdata[g] = mem[ext_addr[g]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM contents: preloaded while in reset, written by instance 0 only.
    always @(posedge clk) begin
        if (!rst) begin
            mem[16'h1234] <= 8'hA5;
            mem[16'h0040] <= 8'h11;
            mem[16'h0041] <= 8'h77;
            mem[16'h0042] <= 8'h5A;
        end else if (!ce_n[0] && !we_n[0]) begin
            mem[ext_addr[0]] <= ext_wdata[0];
        end
    end

    // Strobe activity counters, sampled away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!oe_n[i]) oe_cnt[i]++;
            if (!we_n[i]) we_cnt[i]++;
            if (!oe_n[i] && !we_n[i]) ovl_cnt++;
            if (ce_n[i] && (!oe_n[i] || !we_n[i])) ovl_cnt++;
            if (!ce_n[i] && ce_prev[i]) seq_cnt[i]++;
            ce_prev[i] = ce_n[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One CPU transfer; request inputs are scrambled mid-ACCESS to show they are latched.
    task automatic xfer(input bit rd, input logic [15:0] a, input logic [7:0] d,
                        input int extra, input logic [7:0] exp_dout);
        int oe0[N], we0[N], sq0[N], lat[N];
        bit [N-1:0] done;
        done = '0;
        for (int i = 0; i < N; i++) begin
            oe0[i] = oe_cnt[i]; we0[i] = we_cnt[i]; sq0[i] = seq_cnt[i]; lat[i] = 0;
        end
        addr = a; din = d; read = rd; write = !rd;
        for (int k = 1; k <= 40 && done != '1; k++) begin
            tick();
            if (k == 2) begin
                addr = ~a;
                din  = ~d;
            end
            for (int i = 0; i < N; i++)
                if (!done[i] && ready[i]) begin
                    done[i] = 1'b1;
                    lat[i]  = k - 1;
                end
        end
        chk("done", 32'(done), 32'h7);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("lat%0d", i), 32'(lat[i]), 32'(weff(i) + 1));
            chk($sformatf("oe_cyc%0d", i), 32'(oe_cnt[i] - oe0[i]), rd ? 32'(weff(i)) : 32'd0);
            chk($sformatf("we_cyc%0d", i), 32'(we_cnt[i] - we0[i]), rd ? 32'd0 : 32'(weff(i)));
            chk($sformatf("ext_addr%0d", i), 32'(ext_addr[i]), 32'(a));
            chk($sformatf("dout%0d", i), 32'(dout[i]), 32'(exp_dout));
            if (!rd) chk($sformatf("wdata%0d", i), 32'(ext_wdata[i]), 32'(d));
        end
        repeat (extra) tick();
        chk("hold_rdy", 32'(ready), 32'h7);
        chk("hold_strb", 32'({ce_n, oe_n, we_n}), 32'h1FF);
        for (int i = 0; i < N; i++)
            chk($sformatf("one_seq%0d", i), 32'(seq_cnt[i] - sq0[i]), 32'd1);
        read = 1'b0; write = 1'b0;
        tick();
        chk("idle_rdy", 32'(ready), 32'h0);
    endtask

    initial begin
        int sq;
        rst = 1'b0; read = 1'b0; write = 1'b0; addr = '0; din = '0;
        repeat (2) tick();
        chk("rst_strb", 32'({ce_n, oe_n, we_n}), 32'h1FF);
        chk("rst_rdy", 32'(ready), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_dout", 32'(dout[0]), 32'h00);
        chk("rst_addr", 32'(ext_addr[0]), 32'h0000);
        chk("rst_wdata", 32'(ext_wdata[0]), 32'h00);
        rst = 1'b1;
        tick();

        xfer(1'b1, 16'h1234, 8'h00, 0, 8'hA5);
        xfer(1'b0, 16'h00FF, 8'h3C, 0, 8'hA5);
        xfer(1'b1, 16'h00FF, 8'h00, 5, 8'h3C);

        // Conflicting request: flag error, no access
        sq = seq_cnt[0];
        addr = 16'h0200; read = 1'b1; write = 1'b1;
        tick(); tick();
        chk("err_set", 32'(err), 32'h7);
        chk("err_strb", 32'({ce_n, oe_n, we_n}), 32'h1FF);
        chk("err_noseq", 32'(seq_cnt[0] - sq), 32'd0);
        chk("err_rdy", 32'(ready), 32'h0);
        read = 1'b0; write = 1'b0;
        tick();
        xfer(1'b1, 16'h1234, 8'h00, 0, 8'hA5);
        chk("err_sticky", 32'(err), 32'h7);

        // Reset in the second ACCESS cycle of a read
        xfer(1'b1, 16'h0040, 8'h00, 0, 8'h11);
        addr = 16'h0041; read = 1'b1;
        tick(); tick(); tick();
        chk("abort_oe", 32'(oe_n[0]), 32'h0);
        rst = 1'b0;
        #1;
        chk("abort_strb", 32'({ce_n, oe_n, we_n}), 32'h1FF);
        chk("abort_dout", 32'(dout[0]), 32'h00);
        chk("abort_rdy", 32'(ready), 32'h0);
        chk("abort_err", 32'(err), 32'h0);
        chk("abort_addr", 32'(ext_addr[0]), 32'h0000);
        read = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_idle", 32'({ce_n, oe_n, we_n}), 32'h1FF);
        xfer(1'b1, 16'h0042, 8'h00, 0, 8'h5A);

        chk("no_overlap", 32'(ovl_cnt), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
